// File: rtl/mouse_cfg_pkg.sv
// Shared types and constants for the mouse configuration sequencer.
// Screen defaults are the same figures the VGA timing uses.
package mouse_cfg_pkg;

    localparam int VALUE_W = 12;

    localparam logic [1:0] WR_MAXX = 2'd0;
    localparam logic [1:0] WR_MAXY = 2'd1;
    localparam logic [1:0] WR_SETX = 2'd2;
    localparam logic [1:0] WR_SETY = 2'd3;

    localparam int SCREEN_MAX_X  = 1023;
    localparam int SCREEN_MAX_Y  = 767;
    localparam int SCREEN_INIT_X = 512;
    localparam int SCREEN_INIT_Y = 384;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_GAP,
        ST_DONE
    } state_t;

    typedef logic [VALUE_W-1:0] value_t;

    function automatic value_t clamp_to(input value_t v, input value_t lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/mouse_cfg_sequencer_timer.sv
// Phase down-counter: loads a length-1 value, flags terminal count at zero.
// Latency: tc asserts load_val cycles after the load edge.
// Backpressure: none, free-running once loaded.
module cfg_phase_timer #(
    parameter int W = 3
) (
    input  logic         pclk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] cnt;

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign tc = (cnt == '0);

endmodule

// File: rtl/mouse_cfg_sequencer.sv
// Writes max X/Y then cursor X/Y into the mouse controller after reset and on request.
// Latency: 4*(1+HOLD+GAP)+1 cycles per sequence; request in IDLE reaches SETUP one cycle later.
// Backpressure: requests while busy are held in a one-deep, last-wins pending slot.
module mouse_cfg_sequencer
    import mouse_cfg_pkg::*;
#(
    parameter int MAX_X       = SCREEN_MAX_X,
    parameter int MAX_Y       = SCREEN_MAX_Y,
    parameter int INIT_X      = SCREEN_INIT_X,
    parameter int INIT_Y      = SCREEN_INIT_Y,
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 2
) (
    input  logic               pclk,
    input  logic               rst,
    input  logic               cfg_req,
    input  logic [VALUE_W-1:0] cfg_max_x,
    input  logic [VALUE_W-1:0] cfg_max_y,
    input  logic [VALUE_W-1:0] cfg_init_x,
    input  logic [VALUE_W-1:0] cfg_init_y,
    output logic               busy,
    output logic               done,
    output logic               setmax_x,
    output logic               setmax_y,
    output logic               setx,
    output logic               sety,
    output logic [VALUE_W-1:0] value
);

    localparam int TMR_W = $clog2(((HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES) + 1);

    state_t       state;
    logic [1:0]   idx;
    logic         start;
    logic         pend;
    logic [3:0]   strb;
    value_t       shadow [4];
    value_t       cap    [4];
    value_t       fresh  [4];

    logic             tmr_load;
    logic             tmr_tc;
    logic [TMR_W-1:0] tmr_val;

    // Clamp the cursor into the requested limits before it is ever latched.
    always_comb begin
        fresh[WR_MAXX] = cfg_max_x;
        fresh[WR_MAXY] = cfg_max_y;
        fresh[WR_SETX] = clamp_to(cfg_init_x, cfg_max_x);
        fresh[WR_SETY] = clamp_to(cfg_init_y, cfg_max_y);
    end

    assign tmr_load = (state == ST_SETUP) || ((state == ST_STROBE) && tmr_tc);
    assign tmr_val  = (state == ST_SETUP) ? TMR_W'(HOLD_CYCLES - 1) : TMR_W'(GAP_CYCLES - 1);

    cfg_phase_timer #(.W(TMR_W)) u_timer (
        .pclk     (pclk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tc       (tmr_tc)
    );

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            idx            <= WR_MAXX;
            start          <= 1'b1;
            pend           <= 1'b0;
            strb           <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            value          <= '0;
            shadow[WR_MAXX] <= value_t'(MAX_X);
            shadow[WR_MAXY] <= value_t'(MAX_Y);
            shadow[WR_SETX] <= clamp_to(value_t'(INIT_X), value_t'(MAX_X));
            shadow[WR_SETY] <= clamp_to(value_t'(INIT_Y), value_t'(MAX_Y));
            for (int i = 0; i < 4; i++) cap[i] <= '0;
        end else begin
            done <= 1'b0;
            // A launch already armed in IDLE counts as busy for request capture.
            if (cfg_req && ((state != ST_IDLE) || start)) begin
                pend <= 1'b1;
                cap  <= fresh;
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        start <= 1'b0;
                        idx   <= WR_MAXX;
                        state <= ST_SETUP;
                        busy  <= 1'b1;
                        value <= shadow[WR_MAXX];
                    end else if (cfg_req) begin
                        shadow <= fresh;
                        start  <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    state <= ST_STROBE;
                    strb  <= 4'b0001 << idx;
                end
                ST_STROBE: begin
                    if (tmr_tc) begin
                        strb  <= '0;
                        state <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (tmr_tc) begin
                        if (idx == WR_SETY) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            idx   <= idx + 2'd1;
                            value <= shadow[idx + 2'd1];
                            state <= ST_SETUP;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    if (cfg_req) begin
                        shadow <= fresh;
                        start  <= 1'b1;
                        pend   <= 1'b0;
                    end else if (pend) begin
                        shadow <= cap;
                        start  <= 1'b1;
                        pend   <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign setmax_x = strb[WR_MAXX];
    assign setmax_y = strb[WR_MAXY];
    assign setx     = strb[WR_SETX];
    assign sety     = strb[WR_SETY];

endmodule

// File: tb/tb_mouse_cfg_sequencer.sv
// Bench for mouse_cfg_sequencer: directed scenarios plus random requests,
// checked every cycle against a sequence-position reference model.
module tb_mouse_cfg_sequencer;

    logic        pclk = 1'b0;
    logic        rst;
    logic        cfg_req;
    logic [11:0] cfg_max_x, cfg_max_y, cfg_init_x, cfg_init_y;
    logic        busy, done, setmax_x, setmax_y, setx, sety;
    logic [11:0] value;

    always #5 pclk = ~pclk;

    mouse_cfg_sequencer #(
        .MAX_X(1023), .MAX_Y(767), .INIT_X(512), .INIT_Y(384),
        .HOLD_CYCLES(4), .GAP_CYCLES(2)
    ) dut (
        .pclk       (pclk),
        .rst        (rst),
        .cfg_req    (cfg_req),
        .cfg_max_x  (cfg_max_x),
        .cfg_max_y  (cfg_max_y),
        .cfg_init_x (cfg_init_x),
        .cfg_init_y (cfg_init_y),
        .busy       (busy),
        .done       (done),
        .setmax_x   (setmax_x),
        .setmax_y   (setmax_y),
        .setx       (setx),
        .sety       (sety),
        .value      (value)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: pos is the cycle offset inside a sequence (0 = first SETUP,
    // 28 = DONE, -1 = idle); every output follows from pos by arithmetic.
    int pos;
    bit arm, pend;
    int cur [4];
    int pv  [4];
    int run_len;

    function automatic int clampv(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    task automatic model_reset();
        pos  = -1;
        arm  = 1'b1;
        pend = 1'b0;
        cur  = '{1023, 767, 512, 384};
        run_len = 0;
    endtask

    task automatic model_edge();
        int fr [4];
        int old;
        fr[0] = int'(cfg_max_x);
        fr[1] = int'(cfg_max_y);
        fr[2] = clampv(int'(cfg_init_x), int'(cfg_max_x));
        fr[3] = clampv(int'(cfg_init_y), int'(cfg_max_y));
        old = pos;
        if (old >= 0 && old < 28) begin
            pos++;
            if (cfg_req) begin pend = 1'b1; pv = fr; end
        end else if (old == 28) begin
            pos = -1;
            if (cfg_req) begin cur = fr; arm = 1'b1; pend = 1'b0; end
            else if (pend) begin cur = pv; arm = 1'b1; pend = 1'b0; end
        end else if (arm) begin
            arm = 1'b0;
            pos = 0;
            if (cfg_req) begin pend = 1'b1; pv = fr; end
        end else if (cfg_req) begin
            cur = fr;
            arm = 1'b1;
        end
    endtask

    task automatic compare();
        int eb, ed, es;
        eb = (pos >= 0 && pos < 28) ? 1 : 0;
        ed = (pos == 28) ? 1 : 0;
        es = 0;
        if (eb == 1 && (pos % 7) >= 1 && (pos % 7) <= 4) es = 1 << (pos / 7);
        chk("busy", busy, eb);
        chk("done", done, ed);
        chk("strobes", {sety, setx, setmax_y, setmax_x}, es);
        chk("strobe_onehot", ($countones({sety, setx, setmax_y, setmax_x}) <= 1), 1);
        if (eb == 1) chk("value", value, cur[pos / 7]);
        if (rst) chk("rst_value", value, 0);
        if (rst) run_len = 0;
        else if (busy) run_len++;
        if (done) begin
            chk("busy_len", run_len, 28);
            run_len = 0;
        end
    endtask

    task automatic step();
        @(posedge pclk);
        if (rst) model_reset();
        else model_edge();
        @(negedge pclk);
        compare();
    endtask

    task automatic req(input int mx, input int my, input int ix, input int iy);
        cfg_req    = 1'b1;
        cfg_max_x  = 12'(mx);
        cfg_max_y  = 12'(my);
        cfg_init_x = 12'(ix);
        cfg_init_y = 12'(iy);
        step();
        cfg_req    = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cfg_req = 1'b0;
        cfg_max_x = '0; cfg_max_y = '0; cfg_init_x = '0; cfg_init_y = '0;
        model_reset();
        repeat (3) step();

        // Defaults sequence straight out of reset.
        rst = 1'b0;
        repeat (40) step();

        // Runtime request from idle.
        req(639, 479, 320, 240);
        repeat (35) step();

        // Cursor X beyond its limit is clamped; Y below its limit passes through.
        req(800, 600, 2000, 100);
        repeat (35) step();

        // Two requests during the auto-sequence: only the last one runs afterwards.
        rst = 1'b1; step(); rst = 1'b0;
        repeat (5) step();
        req(700, 500, 100, 100);
        repeat (5) step();
        req(900, 600, 1000, 50);
        repeat (70) step();

        // Reset in the middle of the SETX strobe, with a request pending.
        req(400, 300, 10, 20);
        repeat (8) step();
        req(200, 100, 5, 5);
        for (int i = 0; i < 40 && pos != 16; i++) step();
        chk("reach_setx_strobe", pos, 16);
        #1 rst = 1'b1;
        #1;
        chk("async_setx", setx, 0);
        chk("async_busy", busy, 0);
        chk("async_value", value, 0);
        repeat (2) step();
        rst = 1'b0;
        repeat (45) step();

        // Random requests with random values, including clamp cases.
        for (int i = 0; i < 1500; i++) begin
            cfg_req    = ($urandom_range(0, 24) == 0);
            cfg_max_x  = 12'($urandom_range(0, 4095));
            cfg_max_y  = 12'($urandom_range(0, 4095));
            cfg_init_x = 12'($urandom_range(0, 4095));
            cfg_init_y = 12'($urandom_range(0, 4095));
            step();
        end
        cfg_req = 1'b0;
        repeat (70) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
